// File: rtl/led_enc_pkg.sv
// Shared types and sizing for the LED group encoder.
// The LED bus is N_GROUPS groups of GROUP_W bits each.
package led_enc_pkg;

    localparam int N_GROUPS = 4;
    localparam int GROUP_W  = 2;
    localparam int LED_W    = N_GROUPS * GROUP_W;
    localparam int KEY_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int ACT_W    = $clog2(N_GROUPS + 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_OFFER,
        S_HOLD,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [ACT_W-1:0]   n_active;
        logic [KEY_W-1:0]   key;
        logic [GROUP_W-1:0] sw;
    } decode_t;

    // A group is active when any of its bits is set; key/sw describe the
    // highest-indexed active group, which is the only one when n_active == 1.
    function automatic decode_t decode_groups(input logic [LED_W-1:0] pat);
        decode_t d;
        d = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (pat[g*GROUP_W +: GROUP_W] != '0) begin
                d.n_active = d.n_active + ACT_W'(1);
                d.key      = KEY_W'(g);
                d.sw       = pat[g*GROUP_W +: GROUP_W];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/led_settle_filter.sv
// Synchronizes the asynchronous LED bus and reports when the synced value has
// stayed unchanged for STABLE_CYCLES cycles.
module led_settle_filter
    import led_enc_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_W-1:0] led_in,
    output logic [LED_W-1:0] ref_pat,
    output logic             stable,
    output logic             changed
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [LED_W-1:0] s1;
    logic [LED_W-1:0] s2;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here uses <= so that s1 -> s2 -> ref_pat shifts by
    // exactly one stage per edge; blocking assignments would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            ref_pat <= '0;
            cnt     <= '0;
        end else begin
            s1 <= led_in;
            s2 <= s1;
            if (s2 != ref_pat) begin
                ref_pat <= s2;
                cnt     <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign stable  = (cnt == CNT_MAX);
    assign changed = (s2 != ref_pat);

endmodule

// File: rtl/led_group_encoder.sv
// Recovers key/sw from a settled LED group pattern and offers each distinct
// stable pattern once on a valid/ready interface; multi-group patterns raise err.
module led_group_encoder
    import led_enc_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LED_W-1:0]   led_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [KEY_W-1:0]   key_out,
    output logic [GROUP_W-1:0] sw_out,
    output logic               err
);

    logic [LED_W-1:0] ref_pat;
    logic             stable;
    logic             changed;
    decode_t          dec;
    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             chg_seen_q;
    logic             chg_seen_d;

    led_settle_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .led_in (led_in),
        .ref_pat(ref_pat),
        .stable (stable),
        .changed(changed)
    );

    assign dec = decode_groups(ref_pat);

    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        chg_seen_d = chg_seen_q;
        case (state_q)
            S_WAIT: begin
                chg_seen_d = 1'b0;
                if (stable) begin
                    if (dec.n_active == ACT_W'(1)) begin
                        state_d = S_OFFER;
                        load    = 1'b1;
                    end else if (dec.n_active == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_OFFER: begin
                // The filter may settle on a new pattern before acceptance, so
                // remember that a change happened while the payload was frozen.
                if (changed) chg_seen_d = 1'b1;
                if (out_ready) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (changed || chg_seen_q) state_d = S_WAIT;
            end
            S_ERR: begin
                if (changed) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            chg_seen_q <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            key_out    <= '0;
            sw_out     <= '0;
        end else begin
            state_q    <= state_d;
            chg_seen_q <= chg_seen_d;
            out_valid  <= (state_d == S_OFFER);
            err        <= (state_d == S_ERR);
            if (load) begin
                key_out <= dec.key;
                sw_out  <= dec.sw;
            end
        end
    end

endmodule

// File: tb/tb_led_group_encoder.sv
// Scoreboard bench for led_group_encoder: stimulus pushes expected reports,
// a negedge monitor pops and compares on each handshake or err assertion.
module tb_led_group_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] key_out;
    logic [1:0] sw_out;
    logic       err;

    led_group_encoder #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .led_in   (led_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .key_out  (key_out),
        .sw_out   (sw_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] key;
        logic [1:0] sw;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] prev_pat = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output with empty scoreboard (t=%0t)", name, $time);
    endtask

    // Reference rule: 0 = all groups dark, 1 = exactly one lit group, 2 = several.
    function automatic int model(input logic [7:0] p, output exp_t e);
        int n;
        n = 0;
        e.is_err = 1'b0;
        e.key    = 2'd0;
        e.sw     = 2'd0;
        for (int g = 0; g < 4; g++) begin
            logic [7:0] v;
            v = (p >> (2 * g)) & 8'h03;
            if (v != 8'h00) begin
                n++;
                e.key = 2'(g);
                e.sw  = v[1:0];
            end
        end
        if (n == 0) return 0;
        if (n > 1) begin
            e.is_err = 1'b1;
            return 2;
        end
        return 1;
    endfunction

    // A pattern that becomes stable after a change (or after a glitch) is
    // reported once; dark patterns are never reported.
    task automatic expect_pattern(input logic [7:0] p, input bit forced);
        exp_t e;
        int   k;
        k = model(p, e);
        if ((forced || p != prev_pat) && k != 0) sb.push_back(e);
        prev_pat = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, input string name);
        int i;
        i = 0;
        while (!out_valid && i < max) begin
            step();
            i++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input int max, input bit rand_ready, input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < max) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            i++;
        end
        check(name, 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin : monitor
        bit         pend;
        bit         err_prev;
        logic [1:0] pk;
        logic [1:0] ps;
        exp_t       e;
        pend     = 1'b0;
        err_prev = 1'b0;
        pk       = 2'd0;
        ps       = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend     = 1'b0;
                err_prev = 1'b0;
            end else begin
                check("valid_err_exclusive", 32'(out_valid & err), 32'd0);
                if (pend) begin
                    check("offer_held", 32'(out_valid), 32'd1);
                    check("offer_key_frozen", 32'(key_out), 32'(pk));
                    check("offer_sw_frozen", 32'(sw_out), 32'(ps));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) fail_now("unexpected_report");
                    else begin
                        e = sb.pop_front();
                        check("report_kind", 32'(e.is_err), 32'd0);
                        check("report_key", 32'(key_out), 32'(e.key));
                        check("report_sw", 32'(sw_out), 32'(e.sw));
                    end
                end
                if (err && !err_prev) begin
                    if (sb.size() == 0) fail_now("unexpected_err");
                    else begin
                        e = sb.pop_front();
                        check("err_kind", 32'(e.is_err), 32'd1);
                    end
                end
                pend     = out_valid && !out_ready;
                pk       = key_out;
                ps       = sw_out;
                err_prev = err;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] b;
        logic [7:0] g;
        exp_t       e;
        int         kind;
        int         grp;
        int         hold;
        bit         gl;

        repeat (3) step();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_key", 32'(key_out), 32'd0);
        check("reset_sw", 32'(sw_out), 32'd0);
        rst_n = 1'b1;

        // 1: dark bus after reset never reports
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1_valid_low", 32'(out_valid), 32'd0);
            check("t1_err_low", 32'(err), 32'd0);
        end

        // 2: single group, exact latency, single report
        led_in    = 8'h20;
        out_ready = 1'b1;
        expect_pattern(8'h20, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t2_valid_before_edge8", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t2_valid_edge8", 32'(out_valid), 32'd1);
        check("t2_key", 32'(key_out), 32'd2);
        check("t2_sw", 32'(sw_out), 32'd2);
        @(posedge clk);
        @(negedge clk);
        check("t2_valid_one_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        repeat (20) step();
        drain(5, 1'b0, "t2_drain");

        // 3: short glitch is swallowed, following pattern reported once
        led_in = 8'h01;
        repeat (3) step();
        led_in = 8'hC0;
        expect_pattern(8'hC0, 1'b1);
        repeat (14) step();
        drain(50, 1'b0, "t3_drain");
        repeat (10) step();

        // 4: payload frozen while the bus moves; new pattern follows acceptance
        out_ready = 1'b0;
        led_in    = 8'h04;
        expect_pattern(8'h04, 1'b0);
        wait_valid(20, "t4_offer");
        led_in = 8'h80;
        expect_pattern(8'h80, 1'b0);
        repeat (10) step();
        check("t4_valid_held", 32'(out_valid), 32'd1);
        check("t4_key_held", 32'(key_out), 32'd1);
        check("t4_sw_held", 32'(sw_out), 32'd1);
        out_ready = 1'b1;
        drain(60, 1'b0, "t4_drain");
        repeat (4) step();

        // 5: two lit groups raise err at edge 8, then a legal pattern recovers
        led_in = 8'h11;
        expect_pattern(8'h11, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("t5_err_before_edge8", 32'(err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t5_err_edge8", 32'(err), 32'd1);
        check("t5_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        repeat (3) step();
        led_in = 8'h10;
        expect_pattern(8'h10, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_err_cleared", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        drain(40, 1'b0, "t5_drain");
        repeat (4) step();

        // 6: reset during an offer clears outputs without a clock edge
        out_ready = 1'b0;
        led_in    = 8'h02;
        expect_pattern(8'h02, 1'b0);
        wait_valid(20, "t6_offer");
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(out_valid), 32'd0);
        check("t6_err_async", 32'(err), 32'd0);
        check("t6_key_async", 32'(key_out), 32'd0);
        check("t6_sw_async", 32'(sw_out), 32'd0);
        sb.delete();
        led_in   = 8'h00;
        prev_pat = 8'h00;
        repeat (2) step();
        rst_n = 1'b1;

        // Randomized segments: legal, multi, dark and arbitrary patterns,
        // optionally preceded by a short glitch, with random consumer stalls.
        for (int s = 0; s < 40; s++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 40) begin
                grp = int'($urandom_range(0, 3));
                b   = 8'($urandom_range(1, 3)) << (2 * grp);
            end else if (kind < 65) begin
                do b = 8'($urandom); while (model(b, e) != 2);
            end else if (kind < 80) begin
                b = 8'h00;
            end else begin
                b = 8'($urandom);
            end
            gl = ($urandom_range(0, 9) < 3);
            if (gl) begin
                do g = 8'($urandom); while (g == prev_pat || g == b);
                led_in = g;
                repeat (int'($urandom_range(1, 3))) step();
            end
            led_in = b;
            expect_pattern(b, gl);
            hold = 12 + int'($urandom_range(0, 6));
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            drain(200, 1'b1, "rand_drain");
        end

        repeat (10) step();
        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
